bp_sacc_memcpy: RTL and testbench

// - Streaming accelerator behind the io-CCE inside the sacc tile; takes the accelerator slot alongside the VDP.
// - Slave side: CSR accesses that arrive as uncached io_cmd from the io-CCE.
// - Master side: once started, copies len 64-bit dwords from src to dst.

---
 rtl/bp_sacc_memcpy_pkg.sv | 68 ++++++
 rtl/bp_sacc_memcpy_if.sv | 46 ++++
 rtl/bp_sacc_memcpy_csr.sv | 131 +++++++++++++
 rtl/bp_sacc_memcpy.sv | 169 ++++++++++++++++
 tb/tb_bp_sacc_memcpy.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_sacc_memcpy_pkg.sv
// Shared types and constants for the sacc memcpy accelerator: mem message
// layout, CSR map, status bit positions and dword address helper.
package bp_sacc_memcpy_pkg;

    localparam int unsigned paddr_width_p  = 40;
    localparam int unsigned dword_width_p  = 64;
    localparam int unsigned lce_id_width_p = 4;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'b000,
        e_mem_size_2  = 3'b001,
        e_mem_size_4  = 3'b010,
        e_mem_size_8  = 3'b011,
        e_mem_size_16 = 3'b100,
        e_mem_size_32 = 3'b101,
        e_mem_size_64 = 3'b110
    } bp_mem_size_e;

    typedef enum logic [0:0] {
        e_sacc_vdp     = 1'b0,
        e_sacc_memcpy  = 1'b1
    } bp_sacc_type_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0] lce_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        bp_cce_mem_payload_s       payload;
        bp_mem_size_e              size;
        logic [paddr_width_p-1:0]  addr;
        bp_cce_mem_cmd_type_e      msg_type;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        bp_cce_mem_msg_header_s    header;
        logic [dword_width_p-1:0]  data;
    } bp_cce_mem_msg_s;

    localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    localparam logic [7:0] bp_sacc_memcpy_src_csr_addr_gp    = 8'h00;
    localparam logic [7:0] bp_sacc_memcpy_dst_csr_addr_gp    = 8'h08;
    localparam logic [7:0] bp_sacc_memcpy_len_csr_addr_gp    = 8'h10;
    localparam logic [7:0] bp_sacc_memcpy_start_csr_addr_gp  = 8'h18;
    localparam logic [7:0] bp_sacc_memcpy_status_csr_addr_gp = 8'h20;
    localparam logic [7:0] bp_sacc_memcpy_count_csr_addr_gp  = 8'h28;

    localparam int unsigned bp_sacc_memcpy_status_busy_bit_gp = 0;
    localparam int unsigned bp_sacc_memcpy_status_done_bit_gp = 1;
    localparam int unsigned bp_sacc_memcpy_status_err_bit_gp  = 2;

    // base + 8*idx, wrapping modulo the physical address width
    function automatic logic [paddr_width_p-1:0] bp_sacc_memcpy_dword_addr(
        input logic [paddr_width_p-1:0] base,
        input logic [paddr_width_p-1:0] idx
    );
        return base + (idx << 3);
    endfunction

endpackage

// File: rtl/bp_sacc_memcpy_if.sv
// Bundle of the four io message channels around the memcpy accelerator:
// CSR cmd/resp from the io-CCE and copy cmd/resp toward the LCE link.
interface bp_sacc_memcpy_if;
    import bp_sacc_memcpy_pkg::*;

    bp_cce_mem_msg_s io_cmd_i;
    logic            io_cmd_v_i;
    logic            io_cmd_ready_o;

    bp_cce_mem_msg_s io_resp_o;
    logic            io_resp_v_o;
    logic            io_resp_yumi_i;

    bp_cce_mem_msg_s io_cmd_o;
    logic            io_cmd_v_o;
    logic            io_cmd_yumi_i;

    bp_cce_mem_msg_s io_resp_i;
    logic            io_resp_v_i;
    logic            io_resp_ready_o;

    // Accelerator side
    modport slave (
        input  io_cmd_i, io_cmd_v_i,
        output io_cmd_ready_o,
        output io_resp_o, io_resp_v_o,
        input  io_resp_yumi_i,
        output io_cmd_o, io_cmd_v_o,
        input  io_cmd_yumi_i,
        input  io_resp_i, io_resp_v_i,
        output io_resp_ready_o
    );

    // io-CCE / LCE-link side
    modport master (
        output io_cmd_i, io_cmd_v_i,
        input  io_cmd_ready_o,
        input  io_resp_o, io_resp_v_o,
        output io_resp_yumi_i,
        input  io_cmd_o, io_cmd_v_o,
        output io_cmd_yumi_i,
        output io_resp_i, io_resp_v_i,
        input  io_resp_ready_o
    );

endinterface

// File: rtl/bp_sacc_memcpy_csr.sv
// CSR slave for the memcpy accelerator: accepts one uncached cmd, answers it
// the next cycle, and owns the SRC/DST/LEN registers and the START pulse.
module bp_sacc_memcpy_csr
    import bp_sacc_memcpy_pkg::*;
#(
    parameter int unsigned len_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  bp_cce_mem_msg_s           cmd_i,
    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,

    output bp_cce_mem_msg_s           resp_o,
    output logic                      resp_v_o,
    input  logic                      resp_yumi_i,

    input  logic                      busy_i,
    input  logic                      done_i,
    input  logic                      err_i,
    input  logic [len_width_p-1:0]    count_i,

    output logic [paddr_width_p-1:0]  src_o,
    output logic [paddr_width_p-1:0]  dst_o,
    output logic [len_width_p-1:0]    len_o,
    output logic                      start_o
);

    typedef enum logic {
        e_cfg_ready = 1'b0,
        e_cfg_resp  = 1'b1
    } cfg_state_e;

    cfg_state_e                r_state, w_state_n;
    logic [paddr_width_p-1:0]  r_src, w_src_n;
    logic [paddr_width_p-1:0]  r_dst, w_dst_n;
    logic [len_width_p-1:0]    r_len, w_len_n;
    logic                      r_start, w_start_n;
    bp_cce_mem_msg_s           r_resp, w_resp_n;

    logic [dword_width_p-1:0]  w_rd_data;
    logic [2:0]                w_status;
    logic [7:0]                w_offset;
    logic                      w_is_rd;
    logic                      w_is_wr;
    logic                      w_unused_ok;

    assign w_offset = cmd_i.header.addr[7:0];
    assign w_is_rd  = (cmd_i.header.msg_type == e_cce_mem_uc_rd);
    assign w_is_wr  = (cmd_i.header.msg_type == e_cce_mem_uc_wr);

    assign w_unused_ok = &{1'b0, cmd_i.data[dword_width_p-1:paddr_width_p]};

    // Read mux; STATUS/COUNT reflect the live values at accept time
    always_comb begin
        w_status = '0;
        w_status[bp_sacc_memcpy_status_busy_bit_gp] = busy_i;
        w_status[bp_sacc_memcpy_status_done_bit_gp] = done_i;
        w_status[bp_sacc_memcpy_status_err_bit_gp]  = err_i;
        case (w_offset)
            bp_sacc_memcpy_src_csr_addr_gp:    w_rd_data = dword_width_p'(r_src);
            bp_sacc_memcpy_dst_csr_addr_gp:    w_rd_data = dword_width_p'(r_dst);
            bp_sacc_memcpy_len_csr_addr_gp:    w_rd_data = dword_width_p'(r_len);
            bp_sacc_memcpy_status_csr_addr_gp: w_rd_data = dword_width_p'(w_status);
            bp_sacc_memcpy_count_csr_addr_gp:  w_rd_data = dword_width_p'(count_i);
            default:                           w_rd_data = '0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_src_n   = r_src;
        w_dst_n   = r_dst;
        w_len_n   = r_len;
        w_start_n = 1'b0;
        w_resp_n  = r_resp;
        case (r_state)
            e_cfg_ready: begin
                if (cmd_v_i) begin
                    w_state_n       = e_cfg_resp;
                    w_resp_n.header = cmd_i.header;
                    w_resp_n.data   = w_is_rd ? w_rd_data : '0;
                    // Config writes are acked but dropped while a copy runs
                    if (w_is_wr && !busy_i) begin
                        case (w_offset)
                            bp_sacc_memcpy_src_csr_addr_gp:   w_src_n   = paddr_width_p'(cmd_i.data);
                            bp_sacc_memcpy_dst_csr_addr_gp:   w_dst_n   = paddr_width_p'(cmd_i.data);
                            bp_sacc_memcpy_len_csr_addr_gp:   w_len_n   = len_width_p'(cmd_i.data);
                            bp_sacc_memcpy_start_csr_addr_gp: w_start_n = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            e_cfg_resp: begin
                if (resp_yumi_i) begin
                    w_state_n = e_cfg_ready;
                end
            end
            default: w_state_n = e_cfg_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= e_cfg_ready;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_start <= 1'b0;
            r_resp  <= '0;
        end else begin
            r_state <= w_state_n;
            r_src   <= w_src_n;
            r_dst   <= w_dst_n;
            r_len   <= w_len_n;
            r_start <= w_start_n;
            r_resp  <= w_resp_n;
        end
    end

    assign cmd_ready_o = (r_state == e_cfg_ready);
    assign resp_v_o    = (r_state == e_cfg_resp);
    assign resp_o      = r_resp;
    assign src_o       = r_src;
    assign dst_o       = r_dst;
    assign len_o       = r_len;
    assign start_o     = r_start;

endmodule

// File: rtl/bp_sacc_memcpy.sv
// Memcpy accelerator top: copies LEN dwords from SRC to DST as one uncached
// read then one uncached write per dword, strictly one transaction in flight.
module bp_sacc_memcpy
    import bp_sacc_memcpy_pkg::*;
#(
    parameter int unsigned len_width_p = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [lce_id_width_p-1:0]  lce_id_i,
    bp_sacc_memcpy_if.slave            io
);

    typedef enum logic [2:0] {
        e_idle    = 3'd0,
        e_rd_req  = 3'd1,
        e_rd_wait = 3'd2,
        e_wr_req  = 3'd3,
        e_wr_wait = 3'd4
    } copy_state_e;

    copy_state_e               r_state, w_state_n;
    logic                      r_busy, w_busy_n;
    logic                      r_done, w_done_n;
    logic                      r_err, w_err_n;
    logic [len_width_p-1:0]    r_count, w_count_n;
    logic [dword_width_p-1:0]  r_data, w_data_n;

    logic [paddr_width_p-1:0]  w_src;
    logic [paddr_width_p-1:0]  w_dst;
    logic [len_width_p-1:0]    w_len;
    logic                      w_start;
    logic [len_width_p-1:0]    w_count_inc;
    logic [paddr_width_p-1:0]  w_rd_addr;
    logic [paddr_width_p-1:0]  w_wr_addr;
    logic                      w_unused_ok;

    bp_sacc_memcpy_csr #(
        .len_width_p (len_width_p)
    ) u_csr (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .cmd_i       (io.io_cmd_i),
        .cmd_v_i     (io.io_cmd_v_i),
        .cmd_ready_o (io.io_cmd_ready_o),
        .resp_o      (io.io_resp_o),
        .resp_v_o    (io.io_resp_v_o),
        .resp_yumi_i (io.io_resp_yumi_i),
        .busy_i      (r_busy),
        .done_i      (r_done),
        .err_i       (r_err),
        .count_i     (r_count),
        .src_o       (w_src),
        .dst_o       (w_dst),
        .len_o       (w_len),
        .start_o     (w_start)
    );

    assign w_count_inc = r_count + len_width_p'(1);
    assign w_rd_addr   = bp_sacc_memcpy_dword_addr(w_src, paddr_width_p'(r_count));
    assign w_wr_addr   = bp_sacc_memcpy_dword_addr(w_dst, paddr_width_p'(r_count));
    assign w_unused_ok = &{1'b0, io.io_resp_i.header.addr, io.io_resp_i.header.size,
                           io.io_resp_i.header.payload};

    // Copy-engine next state; a wrong-type response aborts with err set
    always_comb begin
        w_state_n = r_state;
        w_busy_n  = r_busy;
        w_done_n  = r_done;
        w_err_n   = r_err;
        w_count_n = r_count;
        w_data_n  = r_data;
        case (r_state)
            e_idle: begin
                if (w_start) begin
                    w_done_n  = 1'b0;
                    w_err_n   = 1'b0;
                    w_count_n = '0;
                    if (w_len == '0) begin
                        w_done_n = 1'b1;
                    end else begin
                        w_busy_n  = 1'b1;
                        w_state_n = e_rd_req;
                    end
                end
            end
            e_rd_req: begin
                if (io.io_cmd_yumi_i) begin
                    w_state_n = e_rd_wait;
                end
            end
            e_rd_wait: begin
                if (io.io_resp_v_i) begin
                    if (io.io_resp_i.header.msg_type == e_cce_mem_uc_rd) begin
                        w_data_n  = io.io_resp_i.data;
                        w_state_n = e_wr_req;
                    end else begin
                        w_err_n   = 1'b1;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b0;
                        w_state_n = e_idle;
                    end
                end
            end
            e_wr_req: begin
                if (io.io_cmd_yumi_i) begin
                    w_state_n = e_wr_wait;
                end
            end
            e_wr_wait: begin
                if (io.io_resp_v_i) begin
                    if (io.io_resp_i.header.msg_type == e_cce_mem_uc_wr) begin
                        w_count_n = w_count_inc;
                        if (w_count_inc == w_len) begin
                            w_busy_n  = 1'b0;
                            w_done_n  = 1'b1;
                            w_state_n = e_idle;
                        end else begin
                            w_state_n = e_rd_req;
                        end
                    end else begin
                        w_err_n   = 1'b1;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b0;
                        w_state_n = e_idle;
                    end
                end
            end
            default: w_state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_err   <= w_err_n;
            r_count <= w_count_n;
            r_data  <= w_data_n;
        end
    end

    // Outbound cmd is a pure function of registers, so it holds through a stall
    always_comb begin
        io.io_cmd_o                       = '0;
        io.io_cmd_o.header.payload.lce_id = lce_id_i;
        io.io_cmd_o.header.size           = e_mem_size_8;
        if (r_state == e_wr_req) begin
            io.io_cmd_o.header.msg_type = e_cce_mem_uc_wr;
            io.io_cmd_o.header.addr     = w_wr_addr;
            io.io_cmd_o.data            = r_data;
        end else begin
            io.io_cmd_o.header.msg_type = e_cce_mem_uc_rd;
            io.io_cmd_o.header.addr     = w_rd_addr;
        end
    end

    assign io.io_cmd_v_o      = (r_state == e_rd_req) || (r_state == e_wr_req);
    assign io.io_resp_ready_o = (r_state == e_rd_wait) || (r_state == e_wr_wait);

endmodule

// File: tb/tb_bp_sacc_memcpy.sv
// Self-checking bench for bp_sacc_memcpy: CSR driver, LCE-link memory model
// with an expected-command scoreboard, and one task per scenario.
module tb_bp_sacc_memcpy;
    import bp_sacc_memcpy_pkg::*;

    localparam logic [39:0] CSR_BASE = 40'h00_0020_0000;
    localparam logic [3:0]  TB_LCE   = 4'h5;

    logic clk = 1'b0;
    logic reset_n;
    logic [lce_id_width_p-1:0] lce_id;

    always #5 clk = ~clk;

    bp_sacc_memcpy_if bus();

    bp_sacc_memcpy #(.len_width_p(32)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .lce_id_i  (lce_id),
        .io        (bus)
    );

    typedef struct {
        bp_cce_mem_cmd_type_e t;
        logic [39:0]          addr;
        logic [63:0]          data;
    } exp_cmd_t;

    int n_checks = 0;
    int n_errors = 0;

    exp_cmd_t    exp_q[$];
    logic [63:0] mem[logic [39:0]];
    int          served     = 0;
    int          hold_after = -1;
    int          stall_next = 0;
    bit          inject_bad = 1'b0;

    function automatic logic [63:0] pattern(input logic [39:0] a);
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    function automatic logic [63:0] mem_rd(input logic [39:0] a);
        return mem.exists(a) ? mem[a] : pattern(a);
    endfunction

    // Expected rd/wr pair for dword i of a copy
    task automatic push_pair(input logic [39:0] src, input logic [39:0] dst, input int i);
        exp_cmd_t e;
        logic [39:0] sa;
        sa = src + 40'(i * 8);
        e.t = e_cce_mem_uc_rd; e.addr = sa; e.data = '0;
        exp_q.push_back(e);
        e.t = e_cce_mem_uc_wr; e.addr = dst + 40'(i * 8); e.data = mem_rd(sa);
        exp_q.push_back(e);
    endtask

    // LCE-link responder and memory model; pops the scoreboard on each consumed cmd
    initial begin : responder
        bp_cce_mem_msg_s c;
        bp_cce_mem_msg_s r;
        exp_cmd_t        e;
        bit              ok;
        bus.io_cmd_yumi_i = 1'b0;
        bus.io_resp_v_i   = 1'b0;
        bus.io_resp_i     = '0;
        forever begin
            @(posedge clk); #1;
            if (!bus.io_cmd_v_o || served == hold_after) continue;
            c = bus.io_cmd_o;
            for (int s = 0; s < stall_next; s++) begin
                @(posedge clk); #1;
                n_checks++;
                if (bus.io_cmd_v_o !== 1'b1 || bus.io_cmd_o !== c) begin
                    n_errors++;
                    $display("FAIL cmd_stable: stall cycle %0d got v=%b msg=%h, want v=1 msg=%h",
                             s, bus.io_cmd_v_o, bus.io_cmd_o, c);
                end
            end
            stall_next = 0;
            bus.io_cmd_yumi_i = 1'b1;
            @(posedge clk); #1;
            bus.io_cmd_yumi_i = 1'b0;
            served++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_cmd: got type=%0d addr=%h, want no cmd",
                         c.header.msg_type, c.header.addr);
            end else begin
                e = exp_q.pop_front();
                if (c.header.msg_type !== e.t || c.header.addr !== e.addr ||
                    c.header.size !== e_mem_size_8 || c.header.payload.lce_id !== TB_LCE ||
                    (e.t == e_cce_mem_uc_wr && c.data !== e.data)) begin
                    n_errors++;
                    $display("FAIL cmd_content: got type=%0d addr=%h size=%0d lce=%h data=%h, want type=%0d addr=%h size=3 lce=%h data=%h",
                             c.header.msg_type, c.header.addr, c.header.size,
                             c.header.payload.lce_id, c.data, e.t, e.addr, TB_LCE, e.data);
                end
            end
            r.header = c.header;
            if (c.header.msg_type == e_cce_mem_uc_wr) begin
                mem[c.header.addr] = c.data;
                r.data = '0;
            end else begin
                r.data = mem_rd(c.header.addr);
            end
            if (inject_bad) begin
                r.header.msg_type = (c.header.msg_type == e_cce_mem_uc_rd) ? e_cce_mem_uc_wr
                                                                           : e_cce_mem_uc_rd;
                inject_bad = 1'b0;
            end
            bus.io_resp_i   = r;
            bus.io_resp_v_i = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 50 && !ok; w++) begin
                if (bus.io_resp_ready_o) ok = 1'b1;
                else begin @(posedge clk); #1; end
            end
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL resp_accept: got ready=0 for 50 cycles, want ready=1");
            end else begin
                @(posedge clk); #1;
            end
            bus.io_resp_v_i = 1'b0;
        end
    end

    task automatic csr_xact(input bit wr, input logic [7:0] off, input logic [63:0] wdata,
                            output logic [63:0] rdata, output bp_cce_mem_msg_header_s rhdr);
        bit ok;
        rdata = '0;
        rhdr  = '0;
        bus.io_cmd_i.header.msg_type       = wr ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        bus.io_cmd_i.header.addr           = CSR_BASE + {32'd0, off};
        bus.io_cmd_i.header.size           = e_mem_size_8;
        bus.io_cmd_i.header.payload.lce_id = 4'h2;
        bus.io_cmd_i.data                  = wdata;
        bus.io_cmd_v_i                     = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            if (bus.io_cmd_ready_o) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL csr_cmd_timeout: got ready=0 for 50 cycles, want ready=1");
            bus.io_cmd_v_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.io_cmd_v_i = 1'b0;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            if (bus.io_resp_v_o) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL csr_resp_timeout: got resp_v=0 for 50 cycles, want resp_v=1");
            return;
        end
        rdata = bus.io_resp_o.data;
        rhdr  = bus.io_resp_o.header;
        bus.io_resp_yumi_i = 1'b1;
        @(posedge clk); #1;
        bus.io_resp_yumi_i = 1'b0;
    endtask

    task automatic csr_wr(input logic [7:0] off, input logic [63:0] wdata);
        logic [63:0] d;
        bp_cce_mem_msg_header_s h;
        csr_xact(1'b1, off, wdata, d, h);
    endtask

    task automatic csr_rd(input logic [7:0] off, output logic [63:0] rdata);
        bp_cce_mem_msg_header_s h;
        csr_xact(1'b0, off, 64'h0, rdata, h);
    endtask

    task automatic wait_idle(input string name);
        logic [63:0] st;
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            csr_rd(bp_sacc_memcpy_status_csr_addr_gp, st);
            if (st[0] == 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL %s_idle_timeout: got busy=1 after 300 polls, want busy=0", name);
        end
    endtask

    task automatic start_copy(input logic [39:0] src, input logic [39:0] dst, input int len);
        csr_wr(bp_sacc_memcpy_src_csr_addr_gp, {24'd0, src});
        csr_wr(bp_sacc_memcpy_dst_csr_addr_gp, {24'd0, dst});
        csr_wr(bp_sacc_memcpy_len_csr_addr_gp, 64'(len));
        csr_wr(bp_sacc_memcpy_start_csr_addr_gp, 64'hDEAD);
    endtask

    task automatic test_reset();
        logic [63:0] d;
        bp_cce_mem_cmd_type_e mt;
        bp_cce_mem_msg_header_s h;
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (bus.io_cmd_ready_o !== 1'b1 || bus.io_cmd_v_o !== 1'b0 ||
            bus.io_resp_v_o !== 1'b0 || bus.io_resp_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got ready=%b cmd_v=%b resp_v=%b resp_ready=%b, want 1 0 0 0",
                     bus.io_cmd_ready_o, bus.io_cmd_v_o, bus.io_resp_v_o, bus.io_resp_ready_o);
        end
        reset_n = 1'b1;
        csr_xact(1'b0, bp_sacc_memcpy_status_csr_addr_gp, 64'h0, d, h);
        n_checks++;
        if (d !== 64'h0) begin
            n_errors++; $display("FAIL reset_status: got %h, want 0", d);
        end
        mt = e_cce_mem_uc_rd;
        n_checks++;
        if (h.addr !== CSR_BASE + 40'h20 || h.msg_type !== mt || h.payload.lce_id !== 4'h2) begin
            n_errors++;
            $display("FAIL resp_header: got addr=%h type=%0d lce=%h, want addr=%h type=2 lce=2",
                     h.addr, h.msg_type, h.payload.lce_id, CSR_BASE + 40'h20);
        end
        csr_rd(bp_sacc_memcpy_count_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'h0) begin
            n_errors++; $display("FAIL reset_count: got %h, want 0", d);
        end
    endtask

    task automatic test_copy4();
        logic [39:0] src, dst;
        logic [63:0] d;
        src = 40'h00_8000_0000;
        dst = 40'h00_8000_1000;
        for (int i = 0; i < 4; i++) push_pair(src, dst, i);
        start_copy(src, dst, 4);
        wait_idle("copy4");
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL copy4_cmds: got %0d missing cmds, want 0", exp_q.size());
        end
        csr_rd(bp_sacc_memcpy_count_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'd4) begin
            n_errors++; $display("FAIL copy4_count: got %0d, want 4", d);
        end
        csr_rd(bp_sacc_memcpy_status_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'h2) begin
            n_errors++; $display("FAIL copy4_status: got %h, want 2", d);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem_rd(dst + 40'(i * 8)) !== pattern(src + 40'(i * 8))) begin
                n_errors++;
                $display("FAIL copy4_dst[%0d]: got %h, want %h", i,
                         mem_rd(dst + 40'(i * 8)), pattern(src + 40'(i * 8)));
            end
        end
    endtask

    task automatic test_len_zero();
        logic [63:0] d;
        int s0;
        s0 = served;
        csr_wr(bp_sacc_memcpy_len_csr_addr_gp, 64'd0);
        csr_wr(bp_sacc_memcpy_start_csr_addr_gp, 64'd1);
        csr_rd(bp_sacc_memcpy_status_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'h2) begin
            n_errors++; $display("FAIL len0_status: got %h, want 2", d);
        end
        csr_rd(bp_sacc_memcpy_count_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'h0) begin
            n_errors++; $display("FAIL len0_count: got %0d, want 0", d);
        end
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (served != s0 || bus.io_cmd_v_o !== 1'b0) begin
            n_errors++;
            $display("FAIL len0_no_cmd: got %0d cmds v=%b, want 0 cmds v=0", served - s0, bus.io_cmd_v_o);
        end
    endtask

    task automatic test_stall_cfg_ignored();
        logic [39:0] src, dst;
        logic [63:0] d;
        src = 40'h00_9000_0000;
        dst = 40'h00_9000_2000;
        for (int i = 0; i < 3; i++) push_pair(src, dst, i);
        stall_next = 10;
        start_copy(src, dst, 3);
        csr_wr(bp_sacc_memcpy_src_csr_addr_gp, 64'h0);
        csr_wr(bp_sacc_memcpy_len_csr_addr_gp, 64'd1);
        wait_idle("stall");
        csr_rd(bp_sacc_memcpy_src_csr_addr_gp, d);
        n_checks++;
        if (d !== {24'd0, src}) begin
            n_errors++; $display("FAIL stall_src_kept: got %h, want %h", d, src);
        end
        csr_rd(bp_sacc_memcpy_count_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'd3 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL stall_count: got %0d (left %0d), want 3 (left 0)", d, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [39:0] src, dst;
        logic [63:0] d;
        src = 40'hFF_FFFF_FFF8;
        dst = 40'h00_8000_3000;
        for (int i = 0; i < 2; i++) push_pair(src, dst, i);
        start_copy(src, dst, 2);
        wait_idle("wrap");
        csr_rd(bp_sacc_memcpy_status_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'h2 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL wrap_status: got %h (left %0d), want 2 (left 0)", d, exp_q.size());
        end
    endtask

    task automatic test_bad_resp();
        exp_cmd_t e;
        logic [63:0] d;
        int s0;
        e.t = e_cce_mem_uc_rd; e.addr = 40'h00_8800_0000; e.data = '0;
        exp_q.push_back(e);
        inject_bad = 1'b1;
        start_copy(40'h00_8800_0000, 40'h00_8800_1000, 2);
        wait_idle("badresp");
        csr_rd(bp_sacc_memcpy_status_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'h4) begin
            n_errors++; $display("FAIL badresp_status: got %h, want 4", d);
        end
        s0 = served;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (served != s0 || bus.io_cmd_v_o !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL badresp_quiet: got %0d extra cmds v=%b left=%0d, want 0 v=0 left=0",
                     served - s0, bus.io_cmd_v_o, exp_q.size());
        end
    endtask

    task automatic test_reset_midcopy();
        logic [39:0] src, dst;
        logic [63:0] d;
        bit ok;
        int s0;
        src = 40'h00_A000_0000;
        dst = 40'h00_A000_4000;
        for (int i = 0; i < 2; i++) push_pair(src, dst, i);
        hold_after = served + 4;
        start_copy(src, dst, 8);
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            if (served == hold_after && bus.io_cmd_v_o) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL midcopy_reach: got %0d cmds served, want 4 then pending", served);
        end
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold_after = -1;
        csr_rd(bp_sacc_memcpy_status_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'h0 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL midcopy_reset: got status %h left %0d, want 0 left 0", d, exp_q.size());
        end
        src = 40'h00_A000_0100;
        dst = 40'h00_A000_5000;
        push_pair(src, dst, 0);
        s0 = served;
        start_copy(src, dst, 1);
        wait_idle("postreset");
        csr_rd(bp_sacc_memcpy_count_csr_addr_gp, d);
        n_checks++;
        if (d !== 64'd1 || served - s0 != 2) begin
            n_errors++; $display("FAIL postreset_count: got count %0d cmds %0d, want 1 and 2", d, served - s0);
        end
        n_checks++;
        if (mem_rd(dst) !== pattern(src)) begin
            n_errors++; $display("FAIL postreset_dst: got %h, want %h", mem_rd(dst), pattern(src));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish by 500000, want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        lce_id             = TB_LCE;
        reset_n            = 1'b0;
        bus.io_cmd_i       = '0;
        bus.io_cmd_v_i     = 1'b0;
        bus.io_resp_yumi_i = 1'b0;
        test_reset();
        test_copy4();
        test_len_zero();
        test_stall_cfg_ignored();
        test_wrap();
        test_bad_resp();
        test_reset_midcopy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
